wrapper_ctrl: RTL

Next-generation project wrapper. Adds a Wishbone-programmable control plane between the Caravel user-area signals and one user project. A registered activation FSM drives a settle and drain sequence, a per-pad output-enable mask, a project reset/enable output and a run-cycle counter. Pad and LA widths are parametrised. It replaces the static combinational `active` gating with sequenced, software-controlled gating.

---
 rtl/wrapper_ctrl.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/wrapper_ctrl.sv
// -----------------------------------------------------------------------------
// wrapper_ctrl
//
// Purpose:
//   Wishbone-programmable control plane between the Caravel user-area signals
//   and one user project. A registered activation FSM (IDLE, SETTLE, RUN,
//   DRAIN) sequences the project reset/enable and gates the pad and
//   logic-analyzer outputs. A per-pad output-enable mask and a saturating
//   run-cycle counter are also exposed on the bus.
//
// Register map (byte offsets from WB_BASE):
//   0x00 CTRL        rw  [0] EN, [1] FORCE_HIZ
//   0x04 OEB_MASK_LO rw  [31:0]
//   0x08 OEB_MASK_HI rw  [IO_PADS-33:0], upper bits read 0
//   0x0C STATUS      ro  [1:0] state, [8] active
//   0x10 RUN_CNT     ro  cycles spent in RUN (saturating), any write clears
//   0x14..0x1C       read 0, writes ignored
//
// Ports:
//   wb_clk_i, wb_rst_n_i       clock, asynchronous active-low reset
//   wbs_*                      Wishbone classic slave
//   active                     project-select from the harness
//   la_data_in, la_oen, io_in  pass straight to the project (not used here)
//   la_data_out, io_out/io_oeb gated project outputs (io_oeb: 0 = drive)
//   user_io_out/_oeb, user_la_data_out   outputs coming from the project
//   proj_rst_n_o, proj_en_o    project reset / enable, high only in RUN
//   dbg_state_o                current FSM state (IDLE=0 .. DRAIN=3)
//
// Build option:
//   WRAPPER_CTRL_TRISTATE_EN  when defined, the gated outputs and the
//   Wishbone ack/data float ('z') outside RUN, and the Wishbone outputs also
//   float whenever active=0, so several wrappers can share the buses. When
//   undefined, fixed 0 / all-ones values are driven instead.
//
// Handshake: a request is stb & cyc & address inside WB_BASE..WB_BASE+0x1F.
// The ack is registered one cycle after a request is first seen and is then
// forced low for one cycle, so a held request is never acked back-to-back.
// Writes take effect on the same edge that raises ack; read data is only
// non-zero while ack is high.
// -----------------------------------------------------------------------------
module wrapper_ctrl #(
   parameter int unsigned IO_PADS       = 38,
   parameter int unsigned LA_WIDTH      = 32,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [31:0] WB_BASE       = 32'h3000_0000
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_n_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_cyc_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [31:0]         wbs_adr_i,
   input  logic [31:0]         wbs_dat_i,
   output logic                wbs_ack_o,
   output logic [31:0]         wbs_dat_o,
   input  logic                active,
   input  logic [LA_WIDTH-1:0] la_data_in,
   input  logic [LA_WIDTH-1:0] la_oen,
   output logic [LA_WIDTH-1:0] la_data_out,
   input  logic [IO_PADS-1:0]  io_in,
   output logic [IO_PADS-1:0]  io_out,
   output logic [IO_PADS-1:0]  io_oeb,
   input  logic [IO_PADS-1:0]  user_io_out,
   input  logic [IO_PADS-1:0]  user_io_oeb,
   input  logic [LA_WIDTH-1:0] user_la_data_out,
   output logic                proj_rst_n_o,
   output logic                proj_en_o,
   output logic [1:0]          dbg_state_o
);

   localparam int unsigned HI_W        = IO_PADS - 32;
   localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2,
      ST_DRAIN  = 2'd3
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e            state_q, state_d;
   logic [7:0]        settle_q, settle_d;
   logic [1:0]        ctrl_q, ctrl_d;
   logic [31:0]       mask_lo_q, mask_lo_d;
   logic [HI_W-1:0]   mask_hi_q, mask_hi_d;
   logic [31:0]       run_cnt_q, run_cnt_d;
   logic              ack_q, ack_d;
   logic [31:0]       dat_q, dat_d;

   // ---------------------------------------------------------------------------
   // Wishbone decode
   // ---------------------------------------------------------------------------
   logic [31:0] wb_off;
   logic [2:0]  wb_word;
   logic        wb_hit;
   logic        wb_new;
   logic        wb_wr;
   logic        wr_ctrl, wr_lo, wr_hi, wr_cnt;
   logic [31:0] rd_data;

   // Subtracting the base keeps the range check correct even for a base
   // that is not 32-byte aligned.
   assign wb_off  = wbs_adr_i - WB_BASE;
   assign wb_word = wb_off[4:2];
   assign wb_hit  = wbs_stb_i & wbs_cyc_i & (wb_off[31:5] == 27'd0);
   // ack_q high blocks a new acceptance, producing the one-cycle gap.
   assign wb_new  = wb_hit & ~ack_q;
   assign wb_wr   = wb_new & wbs_we_i;

   assign wr_ctrl = wb_wr & (wb_word == 3'd0);
   assign wr_lo   = wb_wr & (wb_word == 3'd1);
   assign wr_hi   = wb_wr & (wb_word == 3'd2);
   assign wr_cnt  = wb_wr & (wb_word == 3'd4);

   always_comb begin
      rd_data = '0;
      case (wb_word)
         3'd0: rd_data[1:0] = ctrl_q;
         3'd1: rd_data = mask_lo_q;
         3'd2: rd_data[HI_W-1:0] = mask_hi_q;
         3'd3: begin
            rd_data[1:0] = state_q;
            rd_data[8]   = active;
         end
         3'd4: rd_data = run_cnt_q;
         default: rd_data = '0;
      endcase
   end

   assign ack_d = wb_new;
   assign dat_d = (wb_new & ~wbs_we_i) ? rd_data : '0;

   // ---------------------------------------------------------------------------
   // Register file next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      ctrl_d    = ctrl_q;
      mask_lo_d = mask_lo_q;
      mask_hi_d = mask_hi_q;
      if (wr_ctrl && wbs_sel_i[0]) begin
         ctrl_d = wbs_dat_i[1:0];
      end
      if (wr_lo) begin
         for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) begin
               mask_lo_d[b*8 +: 8] = wbs_dat_i[b*8 +: 8];
            end
         end
      end
      if (wr_hi) begin
         for (int i = 0; i < int'(HI_W); i++) begin
            if (wbs_sel_i[i/8]) begin
               mask_hi_d[i] = wbs_dat_i[i];
            end
         end
      end
   end

   // A write clears the counter even if RUN would have incremented it.
   always_comb begin
      run_cnt_d = run_cnt_q;
      if (wr_cnt) begin
         run_cnt_d = '0;
      end else if ((state_q == ST_RUN) && (run_cnt_q != 32'hFFFF_FFFF)) begin
         run_cnt_d = run_cnt_q + 32'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Activation FSM
   // ---------------------------------------------------------------------------
   logic go;
   assign go = ctrl_q[0] & active;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               state_d  = ST_SETTLE;
               settle_d = SETTLE_LOAD;
            end
         end
         ST_SETTLE: begin
            // An abort outranks count expiry.
            if (!go) begin
               state_d = ST_IDLE;
            end else if (settle_q == 8'd0) begin
               state_d = ST_RUN;
            end else begin
               settle_d = settle_q - 8'd1;
            end
         end
         ST_RUN: begin
            if (!go) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q   <= ST_IDLE;
         settle_q  <= '0;
         ctrl_q    <= '0;
         mask_lo_q <= '1;
         mask_hi_q <= '1;
         run_cnt_q <= '0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         ctrl_q    <= ctrl_d;
         mask_lo_q <= mask_lo_d;
         mask_hi_q <= mask_hi_d;
         run_cnt_q <= run_cnt_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: decoded from registered state only
   // ---------------------------------------------------------------------------
   logic               run;
   logic [IO_PADS-1:0] mask_full;
   logic [IO_PADS-1:0] oeb_run;

   assign run          = (state_q == ST_RUN);
   assign mask_full    = {mask_hi_q, mask_lo_q};
   assign oeb_run      = ctrl_q[1] ? '1 : (user_io_oeb | mask_full);
   assign proj_rst_n_o = run;
   assign proj_en_o    = run;
   assign dbg_state_o  = state_q;

`ifdef WRAPPER_CTRL_TRISTATE_EN
   assign io_out      = run ? user_io_out      : 'z;
   assign io_oeb      = run ? oeb_run          : 'z;
   assign la_data_out = run ? user_la_data_out : 'z;
   assign wbs_ack_o   = (run & active) ? ack_q : 1'bz;
   assign wbs_dat_o   = (run & active) ? dat_q : 'z;
`else
   assign io_out      = run ? user_io_out      : '0;
   assign io_oeb      = run ? oeb_run          : '1;
   assign la_data_out = run ? user_la_data_out : '0;
   assign wbs_ack_o   = ack_q;
   assign wbs_dat_o   = dat_q;
`endif

   // Project-side inputs are wired to the project outside this block; the
   // byte-offset bits of the address do not select anything.
   logic unused_sink;
   assign unused_sink = ^{la_data_in, la_oen, io_in, wb_off[1:0]};

endmodule
